north_ardata_rd: RTL

- GDMA read-side counterpart of the north write-address generator.
- Splits a (start_addr, length) request into AXI4 INCR read bursts: first burst ends on a 1 KB boundary, later bursts are ≤256 beats. No burst ever crosses 4 KB.
- Accepts the R channel, checks RLAST/RRESP per burst, forwards 32-bit words to a downstream consumer and signals completion.

---
 rtl/north_axi_pkg.sv | 20 ++
 rtl/north_lenq.sv | 59 +++++
 rtl/north_ardata_rd.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/north_axi_pkg.sv
// Shared AXI read constants and the burst-sizing helper for the north GDMA read path.
package north_axi_pkg;

    localparam logic [1:0] BURST_INCR        = 2'b01;
    localparam logic [2:0] SIZE_4B           = 3'b010;
    localparam logic [3:0] CACHE_NM          = 4'b0011;
    localparam int         MAX_BURST_WORDS   = 256;
    localparam int         BOUNDARY_1K_WORDS = 256;

    // Words in the next burst; the first burst stops at the 1 KB boundary so later
    // ones start aligned and can never straddle a 4 KB page.
    function automatic logic [8:0] burst_words(input logic [7:0]  woff,
                                               input logic [30:0] rem,
                                               input logic        first);
        logic [8:0] cap;
        cap = first ? (9'(BOUNDARY_1K_WORDS) - {1'b0, woff}) : 9'(MAX_BURST_WORDS);
        burst_words = (rem < {22'd0, cap}) ? rem[8:0] : cap;
    endfunction

endpackage

// File: rtl/north_lenq.sv
// Burst-length queue: holds arlen of every issued AR until its final beat returns.
module north_lenq
    import north_axi_pkg::*;
#(
    parameter int AW = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic [7:0] din,
    input  logic       pop,
    output logic [7:0] head,
    output logic       empty,
    output logic       full
);

    localparam int DEPTH = 2 ** AW;

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          push_ok, pop_ok;

    assign empty = (cnt_q == '0);
    assign full  = (cnt_q == (AW+1)'(DEPTH));
    assign head  = mem_q[rp_q];

    always_comb begin
        pop_ok  = pop & ~empty;
        push_ok = push & (~full | pop_ok);
        wp_d    = push_ok ? wp_q + AW'(1) : wp_q;
        rp_d    = pop_ok  ? rp_q + AW'(1) : rp_q;
        cnt_d   = cnt_q;
        if (push_ok && !pop_ok) begin
            cnt_d = cnt_q + (AW+1)'(1);
        end else if (!push_ok && pop_ok) begin
            cnt_d = cnt_q - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
        end else begin
            wp_q  <= wp_d;
            rp_q  <= rp_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wp_q] <= din;
        end
    end

endmodule

// File: rtl/north_ardata_rd.sv
// GDMA read engine: splits (start_addr, length) into AXI INCR read bursts,
// checks each returning burst and forwards the words downstream.
module north_ardata_rd
    import north_axi_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 4,
    parameter int LENQ_AW         = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [48:0] start_addr,
    input  logic [31:0] length,
    input  logic        gdma_start,
    output logic        op_start,
    output logic        gdma_rd_busy,
    output logic        gdma_rd_done,
    output logic        gdma_rd_err,
    output logic [48:0] gdma_ddr_araddr,
    output logic [7:0]  gdma_ddr_arlen,
    output logic [2:0]  gdma_ddr_arsize,
    output logic [1:0]  gdma_ddr_arburst,
    output logic [3:0]  gdma_ddr_arcache,
    output logic [2:0]  gdma_ddr_arprot,
    output logic [3:0]  gdma_ddr_arqos,
    output logic [3:0]  gdma_ddr_arregion,
    output logic        gdma_ddr_arlock,
    output logic        gdma_ddr_arvalid,
    input  logic        gdma_ddr_arready,
    input  logic [31:0] gdma_ddr_rdata,
    input  logic [1:0]  gdma_ddr_rresp,
    input  logic        gdma_ddr_rlast,
    input  logic        gdma_ddr_rvalid,
    output logic        gdma_ddr_rready,
    output logic [31:0] rd_data,
    output logic        rd_valid,
    output logic        rd_last,
    input  logic        rd_ready
);

    localparam logic [4:0] OUT_MAX = 5'(MAX_OUTSTANDING);

    logic        start_prev_q, start_prev_d;
    logic        busy_q, busy_d, done_q, done_d, err_q, err_d;
    logic        arvalid_q, arvalid_d;
    logic [46:0] ar_waddr_q, ar_waddr_d;
    logic [7:0]  arlen_q, arlen_d;
    logic [46:0] next_waddr_q, next_waddr_d;
    logic [30:0] rem_q, rem_d, total_q, total_d, rcvd_q, rcvd_d;
    logic        first_q, first_d;
    logic [7:0]  beat_q, beat_d;
    logic [4:0]  out_q, out_d;

    logic        ar_hs, r_acc, final_beat, last_word, lq_pop;
    logic [8:0]  issued_words, nwords;
    logic [7:0]  lq_head;
    logic        lq_empty, lq_full;
    logic        unused_bits;

    assign gdma_ddr_arsize   = SIZE_4B;
    assign gdma_ddr_arburst  = BURST_INCR;
    assign gdma_ddr_arcache  = CACHE_NM;
    assign gdma_ddr_arprot   = 3'b000;
    assign gdma_ddr_arqos    = 4'b0000;
    assign gdma_ddr_arregion = 4'b0000;
    assign gdma_ddr_arlock   = 1'b0;
    assign gdma_ddr_arvalid  = arvalid_q;
    assign gdma_ddr_araddr   = {ar_waddr_q, 2'b00};
    assign gdma_ddr_arlen    = arlen_q;
    assign gdma_rd_busy      = busy_q;
    assign gdma_rd_done      = done_q;
    assign gdma_rd_err       = err_q;

    assign op_start        = gdma_start & ~start_prev_q & ~busy_q;
    assign ar_hs           = arvalid_q & gdma_ddr_arready;
    assign issued_words    = {1'b0, arlen_q} + 9'd1;
    assign gdma_ddr_rready = rd_ready & ((out_q != '0) | ar_hs);
    assign rd_valid        = gdma_ddr_rvalid & (out_q != '0);
    assign rd_data         = gdma_ddr_rdata;
    assign r_acc           = rd_valid & rd_ready;
    assign final_beat      = (beat_q == lq_head);
    assign lq_pop          = r_acc & final_beat;
    assign last_word       = ((rcvd_q + 31'd1) == total_q);
    assign rd_last         = rd_valid & busy_q & last_word;
    assign unused_bits     = lq_empty | lq_full | (^start_addr[1:0]) | (^length[1:0]);

    always_comb begin
        start_prev_d = gdma_start;
        busy_d       = busy_q;
        done_d       = done_q;
        err_d        = err_q;
        arvalid_d    = arvalid_q;
        ar_waddr_d   = ar_waddr_q;
        arlen_d      = arlen_q;
        next_waddr_d = next_waddr_q;
        rem_d        = rem_q;
        total_d      = total_q;
        rcvd_d       = rcvd_q;
        first_d      = first_q;
        beat_d       = beat_q;
        out_d        = out_q;
        nwords       = '0;

        if (ar_hs) begin
            next_waddr_d = next_waddr_q + 47'(issued_words);
            rem_d        = rem_q - 31'(issued_words);
            first_d      = 1'b0;
        end

        // Beats are counted by handshake; a misplaced rlast only flags an error.
        if (r_acc) begin
            rcvd_d = rcvd_q + 31'd1;
            if (gdma_ddr_rresp != 2'b00) begin
                err_d = 1'b1;
            end
            if (final_beat) begin
                beat_d = '0;
                if (!gdma_ddr_rlast) begin
                    err_d = 1'b1;
                end
            end else begin
                beat_d = beat_q + 8'd1;
                if (gdma_ddr_rlast) begin
                    err_d = 1'b1;
                end
            end
            if (busy_q && last_word) begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end
        end

        if (ar_hs && !lq_pop) begin
            out_d = out_q + 5'd1;
        end else if (!ar_hs && lq_pop) begin
            out_d = out_q - 5'd1;
        end

        if (op_start) begin
            next_waddr_d = start_addr[48:2];
            rem_d        = {1'b0, length[31:2]} + 31'd1;
            total_d      = {1'b0, length[31:2]} + 31'd1;
            rcvd_d       = '0;
            beat_d       = '0;
            first_d      = 1'b1;
            err_d        = 1'b0;
            busy_d       = 1'b1;
            done_d       = 1'b0;
        end

        // AR fields are only reloaded when the channel is free, so they hold until arready.
        if (!arvalid_q || gdma_ddr_arready) begin
            nwords    = burst_words(next_waddr_d[7:0], rem_d, first_d);
            arvalid_d = busy_d && (rem_d != '0) && (out_d < OUT_MAX);
            if (arvalid_d) begin
                ar_waddr_d = next_waddr_d;
                arlen_d    = 8'(nwords - 9'd1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            start_prev_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b1;
            err_q        <= 1'b0;
            arvalid_q    <= 1'b0;
            ar_waddr_q   <= '0;
            arlen_q      <= '0;
            next_waddr_q <= '0;
            rem_q        <= '0;
            total_q      <= '0;
            rcvd_q       <= '0;
            first_q      <= 1'b0;
            beat_q       <= '0;
            out_q        <= '0;
        end else begin
            start_prev_q <= start_prev_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            err_q        <= err_d;
            arvalid_q    <= arvalid_d;
            ar_waddr_q   <= ar_waddr_d;
            arlen_q      <= arlen_d;
            next_waddr_q <= next_waddr_d;
            rem_q        <= rem_d;
            total_q      <= total_d;
            rcvd_q       <= rcvd_d;
            first_q      <= first_d;
            beat_q       <= beat_d;
            out_q        <= out_d;
        end
    end

    north_lenq #(
        .AW(LENQ_AW)
    ) u_lenq (
        .clk  (clk),
        .rst  (rst),
        .push (ar_hs),
        .din  (arlen_q),
        .pop  (lq_pop),
        .head (lq_head),
        .empty(lq_empty),
        .full (lq_full)
    );

endmodule
